// File: rtl/csr_birimi_if.sv
// Bus bundle for csr_birimi: write-back CSR write and trap capture, execute-stage
// read port, and the registered redirect / status outputs.
interface csr_birimi_if;
  logic [11:0] csr_adres_i;
  logic [31:0] csr_veri_i;
  logic        csr_yaz_i;
  logic        exc_i;
  logic [3:0]  mcause_ic_i;
  logic [31:0] mepc_i;
  logic [31:0] mtval_i;
  logic        instret_i;
  logic        mret_i;
  logic [4:0]  fflags_i;
  logic        fflags_yaz_i;
  logic [11:0] csr_oku_adres_i;
  logic [31:0] csr_oku_veri_o;
  logic        csr_oku_gecersiz_o;
  logic        trap_gecerli_o;
  logic [31:0] trap_adres_o;
  logic        donus_gecerli_o;
  logic [31:0] donus_adres_o;
  logic [2:0]  frm_o;
  logic        mie_o;

  modport slave (
    input  csr_adres_i, csr_veri_i, csr_yaz_i, exc_i, mcause_ic_i, mepc_i, mtval_i,
           instret_i, mret_i, fflags_i, fflags_yaz_i, csr_oku_adres_i,
    output csr_oku_veri_o, csr_oku_gecersiz_o, trap_gecerli_o, trap_adres_o,
           donus_gecerli_o, donus_adres_o, frm_o, mie_o
  );

  modport master (
    output csr_adres_i, csr_veri_i, csr_yaz_i, exc_i, mcause_ic_i, mepc_i, mtval_i,
           instret_i, mret_i, fflags_i, fflags_yaz_i, csr_oku_adres_i,
    input  csr_oku_veri_o, csr_oku_gecersiz_o, trap_gecerli_o, trap_adres_o,
           donus_gecerli_o, donus_adres_o, frm_o, mie_o
  );
endinterface

// File: rtl/csr_birimi.sv
// Machine-mode CSR unit: fcsr, mstatus, trap/MRET redirect, cycle/instret counters.
// Define SAYAC_64_BIT_EN for 64-bit mcycle/minstret with mcycleh/minstreth.
module csr_birimi #(
  parameter logic [31:0] MTVEC_SIFIRLAMA = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  csr_birimi_if.slave  bus
);

`ifdef SAYAC_64_BIT_EN
  localparam int CW = 64;
`else
  localparam int CW = 32;
`endif

  logic [7:0]    fcsr_q, fcsr_d;
  logic          mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [1:0]    mst_fs_q, mst_fs_d;
  logic [29:0]   mtvec_q, mtvec_d;
  logic [31:0]   mie_q, mie_d, mscratch_q, mscratch_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [30:0]   mepc_q, mepc_d;
  logic          inh_cy_q, inh_cy_d, inh_ir_q, inh_ir_d;
  logic [CW-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic          trap_gecerli_q, trap_gecerli_d, donus_gecerli_q, donus_gecerli_d;
  logic [31:0]   trap_adres_q, trap_adres_d, donus_adres_q, donus_adres_d;

  logic        wr, fp_wr;
  logic [31:0] d;
  logic [31:0] mstatus_rd, cyh_rd, irh_rd, rd_veri;
  logic        rd_gecersiz;

  always_comb begin
    wr              = bus.csr_yaz_i & ~bus.exc_i & ~bus.mret_i;
    d               = bus.csr_veri_i;
    fp_wr           = 1'b0;
    fcsr_d          = fcsr_q;
    mst_mie_d       = mst_mie_q;
    mst_mpie_d      = mst_mpie_q;
    mst_fs_d        = mst_fs_q;
    mtvec_d         = mtvec_q;
    mie_d           = mie_q;
    mscratch_d      = mscratch_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    inh_cy_d        = inh_cy_q;
    inh_ir_d        = inh_ir_q;
    mcycle_d        = mcycle_q + {{(CW-1){1'b0}}, ~inh_cy_q};
    minstret_d      = minstret_q + {{(CW-1){1'b0}}, bus.instret_i & ~inh_ir_q};
    trap_gecerli_d  = bus.exc_i;
    donus_gecerli_d = bus.mret_i & ~bus.exc_i;
    trap_adres_d    = trap_adres_q;
    donus_adres_d   = donus_adres_q;

    // Flag accumulation first; an explicit fflags/fcsr write below overrides it.
    if (bus.fflags_yaz_i) fcsr_d[4:0] = fcsr_q[4:0] | bus.fflags_i;

    if (bus.exc_i) begin
      mepc_d       = bus.mepc_i[31:1];
      mcause_d     = {28'b0, bus.mcause_ic_i};
      mtval_d      = bus.mtval_i;
      mst_mpie_d   = mst_mie_q;
      mst_mie_d    = 1'b0;
      trap_adres_d = {mtvec_q, 2'b00};
    end else if (bus.mret_i) begin
      mst_mie_d     = mst_mpie_q;
      mst_mpie_d    = 1'b1;
      donus_adres_d = {mepc_q, 1'b0};
    end else if (wr) begin
      unique case (bus.csr_adres_i)
        12'h001: begin fcsr_d[4:0] = d[4:0]; fp_wr = 1'b1; end
        12'h002: begin fcsr_d[7:5] = d[2:0]; fp_wr = 1'b1; end
        12'h003: begin fcsr_d      = d[7:0]; fp_wr = 1'b1; end
        12'h300: begin
          mst_mie_d  = d[3];
          mst_mpie_d = d[7];
          mst_fs_d   = d[14:13];
        end
        12'h304: mie_d      = d;
        12'h305: mtvec_d    = d[31:2];
        12'h320: begin inh_cy_d = d[0]; inh_ir_d = d[2]; end
        12'h340: mscratch_d = d;
        12'h341: mepc_d     = d[31:1];
        12'h342: mcause_d   = d;
        12'h343: mtval_d    = d;
`ifdef SAYAC_64_BIT_EN
        // A half-write freezes the other half for this cycle (no increment, no carry).
        12'hB00: mcycle_d   = {mcycle_q[63:32], d};
        12'hB80: mcycle_d   = {d, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], d};
        12'hB82: minstret_d = {d, minstret_q[31:0]};
`else
        12'hB00: mcycle_d   = d;
        12'hB02: minstret_d = d;
`endif
        default: ;
      endcase
    end

    if (bus.fflags_yaz_i | fp_wr) mst_fs_d = 2'b11;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fcsr_q          <= '0;
      mst_mie_q       <= 1'b0;
      mst_mpie_q      <= 1'b0;
      mst_fs_q        <= '0;
      mtvec_q         <= MTVEC_SIFIRLAMA[31:2];
      mie_q           <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      inh_cy_q        <= 1'b0;
      inh_ir_q        <= 1'b0;
      mcycle_q        <= '0;
      minstret_q      <= '0;
      trap_gecerli_q  <= 1'b0;
      donus_gecerli_q <= 1'b0;
      trap_adres_q    <= '0;
      donus_adres_q   <= '0;
    end else begin
      fcsr_q          <= fcsr_d;
      mst_mie_q       <= mst_mie_d;
      mst_mpie_q      <= mst_mpie_d;
      mst_fs_q        <= mst_fs_d;
      mtvec_q         <= mtvec_d;
      mie_q           <= mie_d;
      mscratch_q      <= mscratch_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
      inh_cy_q        <= inh_cy_d;
      inh_ir_q        <= inh_ir_d;
      mcycle_q        <= mcycle_d;
      minstret_q      <= minstret_d;
      trap_gecerli_q  <= trap_gecerli_d;
      donus_gecerli_q <= donus_gecerli_d;
      trap_adres_q    <= trap_adres_d;
      donus_adres_q   <= donus_adres_d;
    end
  end

  // MPP is hardwired to machine mode.
  assign mstatus_rd = {17'b0, mst_fs_q, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
`ifdef SAYAC_64_BIT_EN
  assign cyh_rd = mcycle_q[63:32];
  assign irh_rd = minstret_q[63:32];
`else
  assign cyh_rd = '0;
  assign irh_rd = '0;
`endif

  always_comb begin
    rd_veri     = '0;
    rd_gecersiz = 1'b0;
    unique case (bus.csr_oku_adres_i)
      12'h001: rd_veri = {27'b0, fcsr_q[4:0]};
      12'h002: rd_veri = {29'b0, fcsr_q[7:5]};
      12'h003: rd_veri = {24'b0, fcsr_q};
      12'h300: rd_veri = mstatus_rd;
      12'h301: rd_veri = 32'h4000_1124;
      12'h304: rd_veri = mie_q;
      12'h305: rd_veri = {mtvec_q, 2'b00};
      12'h310: rd_veri = '0;
      12'h320: rd_veri = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
      12'h340: rd_veri = mscratch_q;
      12'h341: rd_veri = {mepc_q, 1'b0};
      12'h342: rd_veri = mcause_q;
      12'h343: rd_veri = mtval_q;
      12'hB00: rd_veri = mcycle_q[31:0];
      12'hB02: rd_veri = minstret_q[31:0];
      12'hB80: rd_veri = cyh_rd;
      12'hB82: rd_veri = irh_rd;
      default: rd_gecersiz = 1'b1;
    endcase
  end

  assign bus.csr_oku_veri_o     = rd_veri;
  assign bus.csr_oku_gecersiz_o = rd_gecersiz;
  assign bus.trap_gecerli_o     = trap_gecerli_q;
  assign bus.trap_adres_o       = trap_adres_q;
  assign bus.donus_gecerli_o    = donus_gecerli_q;
  assign bus.donus_adres_o      = donus_adres_q;
  assign bus.frm_o              = fcsr_q[7:5];
  assign bus.mie_o              = mst_mie_q;

  logic unused_ok;
  assign unused_ok = ^{bus.mepc_i[0], MTVEC_SIFIRLAMA[1:0]};

endmodule

// File: tb/tb_csr_birimi.sv
// Self-checking bench for csr_birimi: table-driven write/readback through a
// scoreboard queue, then hand sequences for trap, MRET, priority, flags and counters.
module tb_csr_birimi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_birimi_if bus();
  csr_birimi #(.MTVEC_SIFIRLAMA(32'h0000_0000)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [11:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_inv;
  } vec_t;

  typedef struct {
    logic [11:0] adr;
    logic [31:0] exp_rd;
    logic        exp_inv;
  } sb_t;

  vec_t vecs[15];
  sb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;
  logic [31:0] v;
  logic        inv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] dv, output logic di);
    bus.csr_oku_adres_i = a;
    #1;
    dv = bus.csr_oku_veri_o;
    di = bus.csr_oku_gecersiz_o;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] dv);
    bus.csr_adres_i = a; bus.csr_veri_i = dv; bus.csr_yaz_i = 1'b1;
    tick();
    bus.csr_yaz_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{12'h301, 32'hFFFF_FFFF, 32'h4000_1124, 1'b0};
    vecs[2]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_7888, 1'b0};
    vecs[3]  = '{12'h310, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[4]  = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0};
    vecs[5]  = '{12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[6]  = '{12'h320, 32'hFFFF_FFFF, 32'h0000_0005, 1'b0};
    vecs[7]  = '{12'h003, 32'h0000_01FF, 32'h0000_00FF, 1'b0};
    vecs[8]  = '{12'h002, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{12'h001, 32'h0000_0003, 32'h0000_0003, 1'b0};
    vecs[10] = '{12'h342, 32'h8000_000B, 32'h8000_000B, 1'b0};
    vecs[11] = '{12'h343, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[12] = '{12'h304, 32'h0000_0888, 32'h0000_0888, 1'b0};
    vecs[13] = '{12'h7C0, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[14] = '{12'h320, 32'h0000_0000, 32'h0000_0000, 1'b0};

    bus.csr_adres_i = '0; bus.csr_veri_i = '0; bus.csr_yaz_i = 1'b0;
    bus.exc_i = 1'b0; bus.mcause_ic_i = '0; bus.mepc_i = '0; bus.mtval_i = '0;
    bus.instret_i = 1'b0; bus.mret_i = 1'b0; bus.fflags_i = '0; bus.fflags_yaz_i = 1'b0;
    bus.csr_oku_adres_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_trap_vld", {31'b0, bus.trap_gecerli_o}, 32'h0);
    chk("rst_donus_vld", {31'b0, bus.donus_gecerli_o}, 32'h0);
    chk("rst_frm_mie", {28'b0, bus.frm_o, bus.mie_o}, 32'h0);
    rd(12'h305, v, inv); chk("rst_mtvec", v, 32'h0);
    rd(12'h300, v, inv); chk("rst_mstatus", v, 32'h0000_1800);

    // Ten clock edges after release
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rd(12'hB00, v, inv); chk("mcycle_10", v, 32'd10);
    rd(12'hB02, v, inv); chk("minstret_0", v, 32'd0);
    rd(12'h300, v, inv); chk("mstatus_1800", v, 32'h0000_1800);

    // Table: same-cycle read sees the old value is skipped; readback after commit
    for (int i = 0; i < 15; i++) begin
      sbq.push_back('{vecs[i].adr, vecs[i].exp_rd, vecs[i].exp_inv});
      wr(vecs[i].adr, vecs[i].wdata);
      begin
        sb_t e;
        e = sbq.pop_front();
        rd(e.adr, v, inv);
        chk($sformatf("tbl%0d_data", i), v, e.exp_rd);
        chk($sformatf("tbl%0d_inv", i), {31'b0, inv}, {31'b0, e.exp_inv});
      end
    end

    // Read in the write cycle returns the old value
    bus.csr_adres_i = 12'h340; bus.csr_veri_i = 32'h0000_1111; bus.csr_yaz_i = 1'b1;
    rd(12'h340, v, inv); chk("old_on_write", v, 32'hDEAD_BEEF);
    tick(); bus.csr_yaz_i = 1'b0;
    wr(12'h340, 32'hDEAD_BEEF);

    // Trap into a direct-mode mtvec
    wr(12'h305, 32'h8000_0103);
    wr(12'h300, 32'h0000_0008);
    bus.exc_i = 1'b1; bus.mepc_i = 32'h8000_01A0; bus.mcause_ic_i = 4'd2; bus.mtval_i = 32'h0;
    tick(); bus.exc_i = 1'b0;
    chk("trap_vld", {31'b0, bus.trap_gecerli_o}, 32'h1);
    chk("trap_adr", bus.trap_adres_o, 32'h8000_0100);
    chk("trap_mie", {31'b0, bus.mie_o}, 32'h0);
    rd(12'h342, v, inv); chk("trap_mcause", v, 32'd2);
    rd(12'h300, v, inv); chk("trap_mpie", {31'b0, v[7]}, 32'h1);
    tick();
    chk("trap_pulse_end", {31'b0, bus.trap_gecerli_o}, 32'h0);

    // MRET back to mepc
    bus.mret_i = 1'b1; tick(); bus.mret_i = 1'b0;
    chk("donus_vld", {31'b0, bus.donus_gecerli_o}, 32'h1);
    chk("donus_adr", bus.donus_adres_o, 32'h8000_01A0);
    chk("donus_mie", {31'b0, bus.mie_o}, 32'h1);
    tick();
    chk("donus_pulse_end", {31'b0, bus.donus_gecerli_o}, 32'h0);

    // exc with a coincident CSR write and MRET: write and MRET are dropped
    bus.exc_i = 1'b1; bus.mret_i = 1'b1;
    bus.csr_adres_i = 12'h340; bus.csr_veri_i = 32'h55; bus.csr_yaz_i = 1'b1;
    tick(); bus.exc_i = 1'b0; bus.mret_i = 1'b0; bus.csr_yaz_i = 1'b0;
    chk("prio_trap", {31'b0, bus.trap_gecerli_o}, 32'h1);
    chk("prio_no_donus", {31'b0, bus.donus_gecerli_o}, 32'h0);
    rd(12'h340, v, inv); chk("prio_mscratch", v, 32'hDEAD_BEEF);

    // MRET beats a coincident CSR write
    bus.mret_i = 1'b1;
    bus.csr_adres_i = 12'h340; bus.csr_veri_i = 32'h77; bus.csr_yaz_i = 1'b1;
    tick(); bus.mret_i = 1'b0; bus.csr_yaz_i = 1'b0;
    rd(12'h340, v, inv); chk("mret_prio_mscratch", v, 32'hDEAD_BEEF);

    // Sticky fflags and FS
    wr(12'h001, 32'h0);
    wr(12'h300, 32'h0);
    bus.fflags_yaz_i = 1'b1; bus.fflags_i = 5'b00001; tick();
    bus.fflags_i = 5'b10000; tick();
    bus.fflags_yaz_i = 1'b0;
    rd(12'h001, v, inv); chk("fflags_sticky", v, 32'h11);
    rd(12'h300, v, inv); chk("fs_dirty", {30'b0, v[14:13]}, 32'h3);
    bus.fflags_yaz_i = 1'b1; bus.fflags_i = 5'b00100;
    wr(12'h003, 32'hE0);
    bus.fflags_yaz_i = 1'b0;
    rd(12'h003, v, inv); chk("fcsr_write_wins", v, 32'hE0);
    chk("frm_o", {29'b0, bus.frm_o}, 32'h7);

    // Instret counting
    wr(12'hB02, 32'h0);
    bus.instret_i = 1'b1; repeat (3) tick(); bus.instret_i = 1'b0;
    rd(12'hB02, v, inv); chk("minstret_3", v, 32'd3);

    // Counter rollover of the low word
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, v, inv); chk("mcycle_max", v, 32'hFFFF_FFFF);
    tick();
    rd(12'hB00, v, inv); chk("mcycle_wrap", v, 32'h0);
    rd(12'hB80, v, inv);
`ifdef SAYAC_64_BIT_EN
    chk("mcycleh_carry", v, 32'h1);
`else
    chk("mcycleh_zero", v, 32'h0);
`endif
    chk("mcycleh_valid", {31'b0, inv}, 32'h0);

    // Reset mid-pulse cancels the trap
    bus.exc_i = 1'b1; bus.mepc_i = 32'h4; tick(); bus.exc_i = 1'b0;
    chk("pre_rst_trap", {31'b0, bus.trap_gecerli_o}, 32'h1);
    #1 rst = 1'b1; #1;
    chk("rst_cancel_trap", {31'b0, bus.trap_gecerli_o}, 32'h0);
    rd(12'h305, v, inv); chk("rst_mtvec_again", v, 32'h0);
    rd(12'h341, v, inv); chk("rst_mepc", v, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/csr_birimi.md
CSR_BIRIMI -- requirements
Module: csr_birimi

Interface
REQ-001 Parameter MTVEC_SIFIRLAMA, 32'h0000_0000, mtvec reset value.
REQ-002 Clock and reset: one clock, clk_i; reset is asynchronous and active-high, rst_i.
REQ-003 clk_i  in  1  clock.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 csr_adres_i / csr_veri_i / csr_yaz_i  in  12/32/1  write-back CSR write port.
REQ-006 exc_i / mcause_ic_i / mepc_i / mtval_i  in  1/4/32/32  write-back trap capture.
REQ-007 instret_i  in  1  instruction retired this cycle.
REQ-008 mret_i  in  1  retiring MRET, already squash-qualified.
REQ-009 fflags_i / fflags_yaz_i  in  5/1  FPU exception flags to accumulate.
REQ-010 csr_oku_adres_i  in  12  read address from execute.
REQ-011 csr_oku_veri_o / csr_oku_gecersiz_o  out  32/1  combinational read data and illegal-address flag.
REQ-012 trap_gecerli_o / trap_adres_o  out  1/32  registered redirect to mtvec.
REQ-013 donus_gecerli_o / donus_adres_o  out  1/32  registered redirect to mepc.
REQ-014 frm_o / mie_o  out  3/1  current rounding mode; mstatus.MIE.

Function
REQ-015 Implemented: fcsr 0x003, frm 0x002, fflags 0x001, misa, mstatus, mstatush, mtvec, mie, mcycle(h), minstret(h), mcountinhibit, mscratch, mepc, mcause, mtval; any other read address -> csr_oku_gecersiz_o=1, data 0.
REQ-016 misa read-only 32'h4000_1124; writes ignored; mstatush reads 0.
REQ-017 mstatus: MIE[3], MPIE[7], FS[14:13] writable; MPP[12:11] reads 2'b11; other bits 0.
REQ-018 mtvec direct mode only: bits [1:0] read 0; mepc bit 0 reads 0.
REQ-019 frm, fflags, fcsr alias one 8-bit state {frm[2:0], fflags[4:0]}.
REQ-020 CSR writes commit on the clk_i edge after csr_yaz_i=1; a read in the same cycle returns the old value.
REQ-021 Trap (exc_i=1): mepc<=mepc_i, mcause<={28'b0,mcause_ic_i}, mtval<=mtval_i, MPIE<=MIE, MIE<=0; next cycle trap_gecerli_o=1 for one cycle, trap_adres_o=mtvec.
REQ-022 MRET (mret_i=1): MIE<=MPIE, MPIE<=1; next cycle donus_gecerli_o=1 for one cycle, donus_adres_o=mepc.
REQ-023 Priority in a cycle: exc_i > mret_i > csr_yaz_i; a lower-priority action coincident with a higher one is discarded entirely.
REQ-024 mcycle increments every cycle unless mcountinhibit[0]; minstret increments when instret_i unless mcountinhibit[2]; mcountinhibit bits other than 0 and 2 read 0.
REQ-025 CSR write to a counter half wins over that cycle's increment; the other half is unchanged and receives no carry that cycle.
REQ-026 Counters wrap to 0 at maximum value, without a flag.
REQ-027 fflags_yaz_i ORs fflags_i into fflags (sticky); a same-cycle CSR write to fflags or fcsr wins and the OR is dropped.
REQ-028 fflags_yaz_i=1 or any fcsr/frm/fflags write sets FS to 2'b11.

Reset
REQ-029 While rst_i=1: every register holds 0, except mtvec=MTVEC_SIFIRLAMA; trap_gecerli_o=0 and donus_gecerli_o=0; frm_o=0 and mie_o=0.
REQ-030 When rst_i asserts mid-operation, a pending trap or donus pulse is cancelled with no partial update.

Configuration
REQ-031 With SAYAC_64_BIT_EN defined, mcycle and minstret are 64-bit, mcycleh and minstreth map the upper words, and a carry propagates from the low to the high word.
REQ-032 With SAYAC_64_BIT_EN undefined, the counters are 32-bit, mcycleh and minstreth read 0 and ignore writes, and are still reported valid.

Verification
REQ-033 Reset release, mcountinhibit=0, 10 cycles -> mcycle reads 10, minstret 0, mstatus 32'h0000_1800.
REQ-034 Write mtvec=0x8000_0103, set MIE, exc_i with mepc_i=0x8000_01A0 and cause 2 -> next cycle trap_gecerli_o=1, trap_adres_o=0x8000_0100, mcause=2, MIE=0, MPIE=1.
REQ-035 mret_i after REQ-034 -> donus_adres_o=0x8000_01A0, MIE=1.
REQ-036 exc_i and csr_yaz_i to mscratch=0x55 in the same cycle -> mscratch unchanged and trap taken.
REQ-037 fflags_yaz_i with 5'b00001, then 5'b10000 -> fflags=5'b10001 and FS=11; CSR write fcsr=0xE0 in the same cycle as a flag -> fcsr=0xE0.
REQ-038 With SAYAC_64_BIT_EN, write mcycle=0xFFFF_FFFF -> next cycle mcycle=0 and mcycleh=1; without the macro -> mcycle=0 and mcycleh=0.
